// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with a built-in
// test-pattern source (solid, colour bars, checkerboard, gradient).
// Ports: clk, rst (async, active high); mode, solid_rgb (sampled at frame start);
//   hsync, vsync, display_en, x, y, line_start, frame_start, frame_count,
//   vga_r/g/b. Every output is registered: one pixel clock of latency.
// Optional: define VGA_SCROLL_EN to scroll modes 1 and 2 left one pixel per frame.
module vga_timing_gen #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int COLOR_W         = 2,
    parameter int CNT_W           = 11,
    parameter int CHECK_SHIFT     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 display_en,
    output logic [CNT_W-1:0]     x,
    output logic [CNT_W-1:0]     y,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [7:0]           frame_count,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int RW      = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS0    = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS1    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS0    = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS1    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic             IDLE   = (SYNC_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]     h_cnt, v_cnt;
    logic                 h_last, v_last, at_origin, frame_wrap;
    logic                 h_vis, v_vis, vis, h_in_sync, v_in_sync;
    logic [1:0]           mode_q, eff_mode;
    logic [3*COLOR_W-1:0] solid_q, eff_solid, pat;
    logic [7:0]           fc_int;
    logic [2:0]           bar_i;
    logic [RW-1:0]        bar_r;
    logic                 chk;
    logic [COLOR_W-1:0]   xy_top;

    // One column step of the bar index: tracks (col*8) = i*H_VISIBLE + r
    // without a divider. Assumes H_VISIBLE >= 8 (at most one bar per pixel).
    function automatic logic [RW+2:0] bar_step(input logic [2:0] i,
                                               input logic [RW-1:0] r);
        logic [RW-1:0] s;
        s = r + RW'(8);
        if (s >= RW'(H_VISIBLE))
            return {i + 3'd1, s - RW'(H_VISIBLE)};
        return {i, s};
    endfunction

    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
    assign frame_wrap = h_last && v_last;
    assign h_vis      = (h_cnt < H_VIS);
    assign v_vis      = (v_cnt < V_VIS);
    assign vis        = h_vis && v_vis;
    assign h_in_sync  = (h_cnt >= HS0) && (h_cnt < HS1);
    assign v_in_sync  = (v_cnt >= VS0) && (v_cnt < VS1);

    // The frame-start pixel already uses the freshly sampled inputs.
    assign eff_mode  = at_origin ? mode : mode_q;
    assign eff_solid = at_origin ? solid_rgb : solid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            fc_int <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last)
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            if (frame_wrap)
                fc_int <= fc_int + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= '0;
            solid_q <= '0;
        end else if (at_origin) begin
            mode_q  <= mode;
            solid_q <= solid_rgb;
        end
    end

`ifdef VGA_SCROLL_EN
    logic [CNT_W-1:0] col;
    logic [2:0]       start_i, start_i_nxt;
    logic [RW-1:0]    start_r, start_r_nxt;

    assign col = h_cnt + CNT_W'(fc_int);
    assign chk = col[CHECK_SHIFT] ^ v_cnt[CHECK_SHIFT];

    // Bar state for the first column of each line; advances one column
    // per frame and returns to zero when frame_count wraps.
    always_comb begin
        {start_i_nxt, start_r_nxt} = {start_i, start_r};
        if (frame_wrap) begin
            if (fc_int == 8'hFF)
                {start_i_nxt, start_r_nxt} = '0;
            else
                {start_i_nxt, start_r_nxt} = bar_step(start_i, start_r);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_i <= '0;
            start_r <= '0;
        end else begin
            start_i <= start_i_nxt;
            start_r <= start_r_nxt;
        end
    end
`else
    localparam logic [2:0]    start_i_nxt = '0;
    localparam logic [RW-1:0] start_r_nxt = '0;

    assign chk = h_cnt[CHECK_SHIFT] ^ v_cnt[CHECK_SHIFT];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_i <= '0;
            bar_r <= '0;
        end else if (h_last) begin
            bar_i <= start_i_nxt;
            bar_r <= start_r_nxt;
        end else begin
            {bar_i, bar_r} <= bar_step(bar_i, bar_r);
        end
    end

    assign xy_top = h_cnt[COLOR_W+4:5] ^ v_cnt[COLOR_W+4:5];

    always_comb begin
        pat = '0;
        case (eff_mode)
            2'd0: pat = eff_solid;
            2'd1: pat = {{COLOR_W{bar_i[2]}}, {COLOR_W{bar_i[1]}},
                         {COLOR_W{bar_i[0]}}};
            2'd2: pat = {(3*COLOR_W){chk}};
            2'd3: pat = {h_cnt[COLOR_W+4:5], v_cnt[COLOR_W+4:5], xy_top};
            default: pat = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= IDLE;
            vsync       <= IDLE;
            display_en  <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            hsync       <= h_in_sync ? !IDLE : IDLE;
            vsync       <= v_in_sync ? !IDLE : IDLE;
            display_en  <= vis;
            x           <= vis ? h_cnt : '0;
            y           <= vis ? v_cnt : '0;
            line_start  <= (h_cnt == '0);
            frame_start <= at_origin;
            frame_count <= fc_int;
            {vga_r, vga_g, vga_b} <= vis ? pat : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen on a 15x8 raster.
// A second instance with active-high syncs shares clock, reset and inputs.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [5:0] solid = 6'b110000;

    logic       hs, vs, de, ls, fs;
    logic [10:0] x, y;
    logic [7:0] fc;
    logic [1:0] r, g, b;

    logic       hs2, vs2, de2, ls2, fs2;
    logic [10:0] x2, y2;
    logic [7:0] fc2;
    logic [1:0] r2, g2, b2;

    int vectors = 0;
    int misc = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE_LOW(1), .COLOR_W(2), .CNT_W(11), .CHECK_SHIFT(1)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid),
        .hsync(hs), .vsync(vs), .display_en(de), .x(x), .y(y),
        .line_start(ls), .frame_start(fs), .frame_count(fc),
        .vga_r(r), .vga_g(g), .vga_b(b)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE_LOW(0), .COLOR_W(2), .CNT_W(11), .CHECK_SHIFT(1)
    ) dut_hi (
        .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid),
        .hsync(hs2), .vsync(vs2), .display_en(de2), .x(x2), .y(y2),
        .line_start(ls2), .frame_start(fs2), .frame_count(fc2),
        .vga_r(r2), .vga_g(g2), .vga_b(b2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misc++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_hs"}, hs, 1);
        chk({tag, "_vs"}, vs, 1);
        chk({tag, "_hs2"}, hs2, 0);
        chk({tag, "_vs2"}, vs2, 0);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_xy"}, {x, y}, 0);
        chk({tag, "_strb"}, {ls, fs}, 0);
        chk({tag, "_fc"}, fc, 0);
        chk({tag, "_rgb"}, {r, g, b}, 0);
    endtask

    initial begin
        int p, h, v;
        logic e_de;

        // Phase 1: reset state, then frame 0 in mode 0
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst0");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            tick();
            p = cyc - 1;
            h = p % 15;
            v = (p / 15) % 8;
            e_de = (h < 8) && (v < 4);
            chk("hsync", hs, (h >= 10 && h <= 12) ? 0 : 1);
            chk("vsync", vs, (v >= 5 && v <= 6) ? 0 : 1);
            chk("hsync_hi", hs2, (h >= 10 && h <= 12) ? 1 : 0);
            chk("vsync_hi", vs2, (v >= 5 && v <= 6) ? 1 : 0);
            chk("de", de, e_de);
            chk("x", x, e_de ? h : 0);
            chk("y", y, e_de ? v : 0);
            chk("line_start", ls, (h == 0) ? 1 : 0);
            chk("frame_start", fs, (p == 0) ? 1 : 0);
            chk("frame_count", fc, 0);
            chk("rgb_solid", {r, g, b}, e_de ? 6'b110000 : 6'b000000);
            if (cyc == 30)
                mode = 2'd2;
        end

        // Frame 1 switches to the checkerboard
        tick();
        chk("f1_fs", fs, 1);
        chk("f1_fc", fc, 1);
        chk("f1_rgb00", {r, g, b}, 6'b000000);
        tick();
        chk("f1_rgb10", {r, g, b}, 6'b000000);
        tick();
        chk("f1_x2", x, 2);
        chk("f1_rgb20", {r, g, b}, 6'b111111);

        // Phase 2: asynchronous reset asserted mid-line at cycle 50
        @(negedge clk);
        rst = 1'b1;
        mode = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        repeat (50) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_state("rst_async");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset_state("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        tick();
        chk("rel_fs", fs, 1);
        chk("rel_ls", ls, 1);
        chk("rel_fc", fc, 0);
        chk("rel_de", de, 1);
        chk("rel_rgb", {r, g, b}, 6'b110000);

        // Phase 3: colour bars, optionally scrolling
        @(negedge clk);
        rst = 1'b1;
        mode = 2'd1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        tick();
        chk("bar_x0_f0", {r, g, b}, 6'b000000);
        tick();
        chk("bar_x1_f0", {r, g, b}, 6'b000011);
        repeat (5) tick();
        chk("bar_x6_f0", {r, g, b}, 6'b111100);
        while (cyc < 121)
            tick();
        chk("bar_f1_fs", fs, 1);
`ifdef VGA_SCROLL_EN
        chk("bar_x0_f1", {r, g, b}, 6'b000011);
`else
        chk("bar_x0_f1", {r, g, b}, 6'b000000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
